// File: rtl/neuron_mac_engine_if.sv
// ----------------------------------------------------------------------------
// neuron_mac_engine_if
// Groups the buses of the neuron MAC engine:
//   - weight RAM read port : w_address, w_chipselect, w_clken (to RAM),
//                            w_readdata (from RAM, one cycle after the address)
//   - input sample stream  : x_data, x_valid (producer), x_ready (engine)
//   - result stream        : y_data, y_valid, y_sat (engine), y_ready (consumer)
// The engine connects through the master modport; the surrounding system
// (RAM, producer, consumer) uses the slave modport.
// ----------------------------------------------------------------------------
interface neuron_mac_engine_if;
    logic [5:0]  w_address;
    logic        w_chipselect;
    logic        w_clken;
    logic [31:0] w_readdata;

    logic [31:0] x_data;
    logic        x_valid;
    logic        x_ready;

    logic [31:0] y_data;
    logic        y_valid;
    logic        y_ready;
    logic        y_sat;

    modport master (
        output w_address, w_chipselect, w_clken, x_ready, y_data, y_valid, y_sat,
        input  w_readdata, x_data, x_valid, y_ready
    );

    modport slave (
        input  w_address, w_chipselect, w_clken, x_ready, y_data, y_valid, y_sat,
        output w_readdata, x_data, x_valid, y_ready
    );
endinterface

// File: rtl/neuron_mac_engine.sv
// ----------------------------------------------------------------------------
// neuron_mac_engine
// Computes one neuron output y = act(bias + sum(x[i]*w[i])) in signed Q format.
// Weights and bias come from the weight RAM read port (weights at addresses
// 0..NUM_INPUTS-1, bias at NUM_INPUTS); samples arrive on a valid/ready stream
// and the saturated (optionally ReLU'd) result leaves on a valid/ready stream.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high; aborts any evaluation in progress
//   start : single-cycle pulse, begins an evaluation when idle
//   busy  : high from the cycle after start is accepted until the y handshake
//   bus   : master side of neuron_mac_engine_if (weight RAM, x stream, y stream)
// ----------------------------------------------------------------------------
module neuron_mac_engine #(
    parameter int NUM_INPUTS = 8,
    parameter int FRAC_BITS  = 16,
    parameter int ACC_W      = 48,
    parameter int RELU       = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    neuron_mac_engine_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE, BIAS_RD, BIAS_LD, FETCH, MAC, ACT, OUT
    } state_t;

    localparam logic [5:0] BIAS_ADDR = 6'(NUM_INPUTS);
    localparam logic [5:0] LAST_IDX  = 6'(NUM_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

    state_t                  state;
    state_t                  state_nxt;
    logic [5:0]              index;
    logic signed [ACC_W-1:0] acc;
    logic signed [63:0]      prod;
    logic signed [ACC_W-1:0] term;
    logic [32:0]             sat_word;
    logic [31:0]             y_act;

    // Clamp the accumulator to signed 32 bits; bit 32 flags that clamping occurred.
    function automatic logic [32:0] sat32(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX)
            return {1'b1, 32'h7FFF_FFFF};
        else if (a < SAT_MIN)
            return {1'b1, 32'h8000_0000};
        else
            return {1'b0, a[31:0]};
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] y);
        return (RELU != 0 && y[31]) ? 32'h0 : y;
    endfunction

    // Full-precision product realigned to the Q format; the arithmetic shift
    // truncates toward -inf and the cast sign-extends or wraps to ACC_W.
    always_comb begin
        prod     = $signed(bus.x_data) * $signed(bus.w_readdata);
        term     = ACC_W'(prod >>> FRAC_BITS);
        sat_word = sat32(acc);
        y_act    = relu(sat_word[31:0]);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // RAM controls stay asserted through MAC so w_readdata holds the weight
    // for as long as the sample stream stalls.
    always_comb begin
        state_nxt        = state;
        bus.w_address    = 6'd0;
        bus.w_chipselect = 1'b0;
        bus.w_clken      = 1'b0;
        bus.x_ready      = 1'b0;
        busy             = (state != IDLE);
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = BIAS_RD;
            end
            BIAS_RD: begin
                bus.w_address    = BIAS_ADDR;
                bus.w_chipselect = 1'b1;
                bus.w_clken      = 1'b1;
                state_nxt        = BIAS_LD;
            end
            BIAS_LD: begin
                bus.w_address    = BIAS_ADDR;
                bus.w_chipselect = 1'b1;
                state_nxt        = FETCH;
            end
            FETCH: begin
                bus.w_address    = index;
                bus.w_chipselect = 1'b1;
                bus.w_clken      = 1'b1;
                state_nxt        = MAC;
            end
            MAC: begin
                bus.w_address    = index;
                bus.w_chipselect = 1'b1;
                bus.w_clken      = 1'b1;
                bus.x_ready      = 1'b1;
                if (bus.x_valid)
                    state_nxt = (index == LAST_IDX) ? ACT : FETCH;
            end
            ACT: begin
                state_nxt = OUT;
            end
            OUT: begin
                if (bus.y_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: bias load, multiply-accumulate, activation and result hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            index       <= 6'd0;
            acc         <= '0;
            bus.y_data  <= 32'h0;
            bus.y_sat   <= 1'b0;
            bus.y_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start)
                        index <= 6'd0;
                end
                BIAS_LD: begin
                    acc <= ACC_W'($signed(bus.w_readdata));
                end
                MAC: begin
                    if (bus.x_valid) begin
                        acc   <= acc + term;
                        index <= index + 6'd1;
                    end
                end
                ACT: begin
                    bus.y_data  <= y_act;
                    bus.y_sat   <= sat_word[32];
                    bus.y_valid <= 1'b1;
                end
                OUT: begin
                    if (bus.y_ready)
                        bus.y_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_engine.sv
// ----------------------------------------------------------------------------
// tb_neuron_mac_engine
// Three engine instances (N=2 ReLU, N=2 identity, N=3 ReLU), each with its own
// weight RAM model. One instance is exercised at a time through shared
// stimulus drivers selected by 'sel'. Cycle numbering inside an evaluation:
// cycle 1 is the cycle right after the edge that samples start.
// ----------------------------------------------------------------------------
module tb_neuron_mac_engine;
    logic clk;
    logic reset;
    logic start_drv;
    logic [31:0] x_data_drv;
    logic x_valid_drv;
    logic y_ready_drv;
    int   sel;

    int ncmp  = 0;
    int nfail = 0;

    int n_of[3]    = '{2, 2, 3};
    bit relu_of[3] = '{1'b1, 1'b0, 1'b1};

    logic [31:0] mem [3][64];
    logic [31:0] rd  [3];
    logic [31:0] xq [$];
    logic [5:0]  addr_q [$];
    bit          cs_q [$];

    logic busy0, busy1, busy2;
    neuron_mac_engine_if b0();
    neuron_mac_engine_if b1();
    neuron_mac_engine_if b2();

    neuron_mac_engine #(.NUM_INPUTS(2), .FRAC_BITS(16), .ACC_W(48), .RELU(1)) dut0 (
        .clk(clk), .reset(reset), .start(start_drv && sel == 0), .busy(busy0), .bus(b0));
    neuron_mac_engine #(.NUM_INPUTS(2), .FRAC_BITS(16), .ACC_W(48), .RELU(0)) dut1 (
        .clk(clk), .reset(reset), .start(start_drv && sel == 1), .busy(busy1), .bus(b1));
    neuron_mac_engine #(.NUM_INPUTS(3), .FRAC_BITS(16), .ACC_W(48), .RELU(1)) dut2 (
        .clk(clk), .reset(reset), .start(start_drv && sel == 2), .busy(busy2), .bus(b2));

    assign b0.x_data  = x_data_drv;
    assign b1.x_data  = x_data_drv;
    assign b2.x_data  = x_data_drv;
    assign b0.x_valid = x_valid_drv && sel == 0;
    assign b1.x_valid = x_valid_drv && sel == 1;
    assign b2.x_valid = x_valid_drv && sel == 2;
    assign b0.y_ready = y_ready_drv && sel == 0;
    assign b1.y_ready = y_ready_drv && sel == 1;
    assign b2.y_ready = y_ready_drv && sel == 2;
    assign b0.w_readdata = rd[0];
    assign b1.w_readdata = rd[1];
    assign b2.w_readdata = rd[2];

    // Synchronous-read RAM models: data appears one cycle after the address.
    always @(posedge clk) begin
        if (b0.w_clken) rd[0] <= mem[0][b0.w_address];
        if (b1.w_clken) rd[1] <= mem[1][b1.w_address];
        if (b2.w_clken) rd[2] <= mem[2][b2.w_address];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        o_busy, o_x_ready, o_y_valid, o_y_sat, o_cs, o_clken;
    logic [31:0] o_y_data;
    logic [5:0]  o_addr;

    always_comb begin
        o_busy = busy0; o_x_ready = b0.x_ready; o_y_valid = b0.y_valid;
        o_y_sat = b0.y_sat; o_y_data = b0.y_data; o_cs = b0.w_chipselect;
        o_clken = b0.w_clken; o_addr = b0.w_address;
        if (sel == 1) begin
            o_busy = busy1; o_x_ready = b1.x_ready; o_y_valid = b1.y_valid;
            o_y_sat = b1.y_sat; o_y_data = b1.y_data; o_cs = b1.w_chipselect;
            o_clken = b1.w_clken; o_addr = b1.w_address;
        end else if (sel == 2) begin
            o_busy = busy2; o_x_ready = b2.x_ready; o_y_valid = b2.y_valid;
            o_y_sat = b2.y_sat; o_y_data = b2.y_data; o_cs = b2.w_chipselect;
            o_clken = b2.w_clken; o_addr = b2.w_address;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the neuron equation, 48-bit wrap,
    // clamp to 32 bits, then optional ReLU. Returns {sat, y}.
    function automatic logic [32:0] ref_y(input int n, input bit relu_on,
                                          input logic [31:0] w [64], input logic [31:0] xs [$]);
        longint acc;
        longint p;
        logic [31:0] y;
        bit s;
        acc = longint'($signed(w[n]));
        for (int i = 0; i < n; i++) begin
            p   = longint'($signed(xs[i])) * longint'($signed(w[i]));
            acc = acc + (p >>> 16);
            acc = (acc <<< 16) >>> 16;
        end
        if (acc > 64'sd2147483647) begin
            y = 32'h7FFF_FFFF; s = 1'b1;
        end else if (acc < -64'sd2147483648) begin
            y = 32'h8000_0000; s = 1'b1;
        end else begin
            y = acc[31:0]; s = 1'b0;
        end
        if (relu_on && y[31]) y = 32'h0;
        return {s, y};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_xr"}, o_x_ready, 1'b0);
        check({tag, "_yv"}, o_y_valid, 1'b0);
        check({tag, "_yd"}, o_y_data, 32'h0);
        check({tag, "_ys"}, o_y_sat, 1'b0);
        check({tag, "_cs"}, o_cs, 1'b0);
        check({tag, "_ce"}, o_clken, 1'b0);
        check({tag, "_addr"}, o_addr, 6'd0);
    endtask

    // One evaluation on instance k, entered and left at a negedge.
    task automatic run(input int k, input int xstall, input int ystall, input bit start_in_out,
                       input int abort_after, output logic [31:0] y, output logic ys);
        int n = n_of[k];
        int sidx = 0, scnt = 0, ycnt = 0, xr_cycles = 0, lat = -1;
        bit seen = 0, done = 0, fire, yfire;
        sel = k;
        y = 32'h0; ys = 1'b0;
        addr_q.delete(); cs_q.delete();
        start_drv = 1'b1;
        @(posedge clk); @(negedge clk);
        start_drv = 1'b0;
        for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
            if (o_clken) addr_q.push_back(o_addr);
            cs_q.push_back(o_cs);
            check("busy_run", o_busy, 1'b1);
            if (cyc <= 3) check("xr_early", o_x_ready, 1'b0);
            if (o_y_valid) begin
                check("xr_out", o_x_ready, 1'b0);
                if (!seen) begin
                    seen = 1; lat = cyc; y = o_y_data; ys = o_y_sat;
                end else begin
                    check("y_hold", {o_y_sat, o_y_data}, {ys, y});
                end
            end
            if (o_x_ready) xr_cycles++;
            if (abort_after >= 0 && sidx == abort_after && o_x_ready) begin
                x_valid_drv = 1'b0;
                reset = 1'b1;
                @(posedge clk); @(negedge clk);
                return;
            end
            if (sidx >= n) begin
                x_valid_drv = 1'b1; x_data_drv = $urandom;
            end else if (scnt >= xstall) begin
                x_valid_drv = 1'b1; x_data_drv = xq[sidx];
            end else begin
                x_valid_drv = 1'b0; x_data_drv = $urandom; scnt++;
            end
            fire = x_valid_drv && o_x_ready;
            y_ready_drv = 1'b0;
            if (seen) begin
                if (ycnt >= ystall) y_ready_drv = 1'b1;
                else ycnt++;
            end
            start_drv = start_in_out && o_y_valid;
            yfire = y_ready_drv && o_y_valid;
            @(posedge clk); @(negedge clk);
            if (fire) begin sidx++; scnt = 0; end
            if (yfire) done = 1;
        end
        start_drv = 1'b0; x_valid_drv = 1'b0; y_ready_drv = 1'b0;
        check("handshake_done", done, 1'b1);
        check("idle_after_busy", o_busy, 1'b0);
        check("idle_after_yv", o_y_valid, 1'b0);
        if (xstall == 0 && ystall == 0) begin
            check("latency", lat, 2 * n + 4);
            check("xr_cycles", xr_cycles, n);
        end
    endtask

    task automatic load_basic(input int k);
        mem[k][0] = 32'h0002_0000;
        mem[k][1] = 32'hFFFF_8000;
        mem[k][2] = 32'h0000_4000;
    endtask

    initial begin
        logic [31:0] y;
        logic ys;
        logic [32:0] e;
        reset = 1'b1; start_drv = 1'b0; x_data_drv = 32'h0;
        x_valid_drv = 1'b0; y_ready_drv = 1'b0; sel = 0;
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 64; a++) mem[k][a] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sel = k; #1;
            check_idle_outputs("reset");
        end
        reset = 1'b0;
        sel = 0;
        @(negedge clk);

        // Basic: 0.25 + 1.5*2.0 + 3.0*(-0.5) = 1.75
        load_basic(0);
        xq = '{32'h0001_8000, 32'h0003_0000};
        run(0, 0, 0, 0, -1, y, ys);
        check("basic_y", y, 32'h0001_C000);
        check("basic_sat", ys, 1'b0);

        // ReLU clamps -7.75 to 0; identity keeps it
        xq = '{32'h0000_0000, 32'h0010_0000};
        run(0, 0, 0, 0, -1, y, ys);
        check("relu_y", y, 32'h0);
        check("relu_sat", ys, 1'b0);
        load_basic(1);
        run(1, 0, 0, 0, -1, y, ys);
        check("norelu_y", y, 32'hFFF8_4000);

        // Positive and negative saturation
        mem[0][0] = 32'h7FFF_FFFF; mem[0][1] = 32'h0; mem[0][2] = 32'h0;
        xq = '{32'h7FFF_FFFF, 32'h0001_2345};
        run(0, 0, 0, 0, -1, y, ys);
        check("satp_y", y, 32'h7FFF_FFFF);
        check("satp_sat", ys, 1'b1);
        mem[1][0] = 32'h7FFF_FFFF; mem[1][1] = 32'h0; mem[1][2] = 32'h0;
        xq = '{32'h8000_0000, 32'h0};
        run(1, 0, 0, 0, -1, y, ys);
        check("satn_y", y, 32'h8000_0000);
        check("satn_sat", ys, 1'b1);

        // Stalls on both streams, start pulses during OUT
        load_basic(0);
        xq = '{32'h0001_8000, 32'h0003_0000};
        run(0, 3, 5, 1, -1, y, ys);
        check("stall_y", y, 32'h0001_C000);
        check("stall_sat", ys, 1'b0);

        // Reset in MAC after the first sample, then a clean rerun
        xq = '{32'h0004_0000, 32'h0005_0000};
        run(0, 0, 0, 0, 1, y, ys);
        check_idle_outputs("abort");
        reset = 1'b0;
        @(negedge clk);
        check("abort_idle_busy", o_busy, 1'b0);
        check("abort_idle_yv", o_y_valid, 1'b0);
        xq = '{32'h0001_8000, 32'h0003_0000};
        run(0, 0, 0, 0, -1, y, ys);
        check("rerun_y", y, 32'h0001_C000);

        // Address and chipselect trace for three inputs
        mem[2][0] = 32'h0001_0000; mem[2][1] = 32'h0000_8000;
        mem[2][2] = 32'hFFFE_0000; mem[2][3] = 32'h0000_1000;
        xq = '{32'h0002_0000, 32'h0004_0000, 32'h0000_8000};
        run(2, 0, 0, 0, -1, y, ys);
        e = ref_y(3, 1'b1, mem[2], xq);
        check("trace_y", {ys, y}, e);
        check("trace_len", addr_q.size(), 7);
        if (addr_q.size() == 7) begin
            logic [5:0] exp_addr [7] = '{6'd3, 6'd0, 6'd0, 6'd1, 6'd1, 6'd2, 6'd2};
            for (int i = 0; i < 7; i++) check("trace_addr", addr_q[i], exp_addr[i]);
        end
        check("cs_len", cs_q.size(), 10);
        for (int i = 0; i < cs_q.size(); i++) check("trace_cs", cs_q[i], (i + 1) <= 8);

        // Randomized evaluations against the reference
        for (int r = 0; r < 12; r++) begin
            int k = r % 3;
            int n = n_of[k];
            bit big = (r % 4 == 0);
            logic [31:0] v;
            for (int a = 0; a <= n; a++) begin
                v = $urandom;
                mem[k][a] = big ? v : {{12{v[19]}}, v[19:0]};
            end
            xq.delete();
            for (int i = 0; i < n; i++) begin
                v = $urandom;
                xq.push_back(big ? v : {{12{v[19]}}, v[19:0]});
            end
            run(k, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 1), -1, y, ys);
            e = ref_y(n, relu_of[k], mem[k], xq);
            check("rand_y", {ys, y}, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
